// File: rtl/irq_arbiter_ctrl_pkg.sv
// Shared types and constants for the prioritising interrupt controller.
// Register map indices, FSM state encoding and the interrupt id width.
package irq_arbiter_ctrl_pkg;

    localparam int IRQ_ID_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } irq_state_e;

    localparam logic [2:0] IRQ_REG_ENABLE  = 3'd0;
    localparam logic [2:0] IRQ_REG_PENDING = 3'd1;
    localparam logic [2:0] IRQ_REG_EDGE    = 3'd2;
    localparam logic [2:0] IRQ_REG_PRIO    = 3'd3;
    localparam logic [2:0] IRQ_REG_THRESH  = 3'd4;
    localparam logic [2:0] IRQ_REG_INSERV  = 3'd5;
    localparam logic [2:0] IRQ_REG_STATE   = 3'd6;

endpackage

// File: rtl/irq_arbiter_ctrl_prio_sel.sv
// Combinational winner selection: highest priority among eligible sources,
// lowest index on ties.
module irq_prio_sel
    import irq_arbiter_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 10,
    parameter int PRIO_W  = 2
) (
    input  logic [NUM_SRC-1:0]        eligible,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    output logic                      found,
    output logic [IRQ_ID_W-1:0]       id
);

    logic [PRIO_W-1:0] best;

    // Strictly-greater replacement while scanning upward keeps the lowest index on ties.
    always_comb begin
        found = 1'b0;
        id    = '0;
        best  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && (!found || (prio[i*PRIO_W +: PRIO_W] > best))) begin
                found = 1'b1;
                id    = IRQ_ID_W'(i);
                best  = prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

endmodule

// File: rtl/irq_arbiter_ctrl.sv
// Prioritising interrupt controller: pending capture, enable/priority/threshold
// filtering and a request/claim/complete handshake towards the trap unit.
module irq_arbiter_ctrl
    import irq_arbiter_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 10,
    parameter int PRIO_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_SRC-1:0]  src_irq,
    input  logic                cfg_rd_en,
    input  logic                cfg_wr_en,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_wr_data,
    output logic [31:0]         cfg_rd_data,
    output logic                irq_req,
    output logic [IRQ_ID_W-1:0] irq_id,
    input  logic                irq_claim,
    input  logic                irq_complete,
    input  logic [IRQ_ID_W-1:0] irq_complete_id
);

    localparam int PRIO_BITS = NUM_SRC * PRIO_W;

    irq_state_e state;

    logic [NUM_SRC-1:0]   enable;
    logic [NUM_SRC-1:0]   pending;
    logic [NUM_SRC-1:0]   edge_sel;
    logic [NUM_SRC-1:0]   inserv;
    logic [NUM_SRC-1:0]   src_prev;
    logic [PRIO_BITS-1:0] prio;
    logic [PRIO_W-1:0]    thresh;

    logic [NUM_SRC-1:0]   prio_ok;
    logic [NUM_SRC-1:0]   id_hit;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   claim_vec;
    logic [NUM_SRC-1:0]   w1c_vec;
    logic [NUM_SRC-1:0]   pending_nxt;
    logic                 id_eligible;
    logic                 claim_fire;
    logic                 complete_fire;
    logic                 win_found;
    logic [IRQ_ID_W-1:0]  win_id;

    logic wr_enable;
    logic wr_pending;
    logic wr_edge;
    logic wr_prio;
    logic wr_thresh;
    logic wr_data_unused;

    assign wr_enable  = cfg_wr_en && (cfg_addr == IRQ_REG_ENABLE);
    assign wr_pending = cfg_wr_en && (cfg_addr == IRQ_REG_PENDING);
    assign wr_edge    = cfg_wr_en && (cfg_addr == IRQ_REG_EDGE);
    assign wr_prio    = cfg_wr_en && (cfg_addr == IRQ_REG_PRIO);
    assign wr_thresh  = cfg_wr_en && (cfg_addr == IRQ_REG_THRESH);
    assign wr_data_unused = ^cfg_wr_data;

    always_comb begin
        prio_ok = '0;
        id_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            prio_ok[i] = prio[i*PRIO_W +: PRIO_W] > thresh;
            id_hit[i]  = irq_id == IRQ_ID_W'(i);
        end
    end

    assign eligible    = pending & enable & ~inserv & prio_ok;
    assign id_eligible = |(eligible & id_hit);

    assign claim_fire    = (state == S_REQ) && irq_req && irq_claim;
    assign complete_fire = (state == S_BUSY) && irq_complete && (irq_complete_id == irq_id);

    assign rise      = src_irq & ~src_prev;
    assign claim_vec = claim_fire ? id_hit : '0;
    assign w1c_vec   = wr_pending ? cfg_wr_data[NUM_SRC-1:0] : '0;

    // A fresh rising edge beats any clear (claim or W1C) landing in the same cycle.
    assign pending_nxt = (~edge_sel & src_irq)
                       | ( edge_sel & (rise | (pending & ~(claim_vec | w1c_vec))));

    irq_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_prio_sel (
        .eligible (eligible),
        .prio     (prio),
        .found    (win_found),
        .id       (win_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            src_prev <= '0;
        end else begin
            pending  <= pending_nxt;
            src_prev <= src_irq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable   <= '0;
            edge_sel <= '0;
            prio     <= '0;
            thresh   <= '0;
        end else begin
            if (wr_enable) begin
                enable <= cfg_wr_data[NUM_SRC-1:0];
            end
            if (wr_edge) begin
                edge_sel <= cfg_wr_data[NUM_SRC-1:0];
            end
            if (wr_prio) begin
                prio <= cfg_wr_data[PRIO_BITS-1:0];
            end
            if (wr_thresh) begin
                thresh <= cfg_wr_data[PRIO_W-1:0];
            end
        end
    end

    // Handshake FSM; in S_BUSY nothing new is offered, so handlers never nest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
            inserv  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        irq_id  <= win_id;
                        irq_req <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (claim_fire) begin
                        inserv  <= inserv | id_hit;
                        irq_req <= 1'b0;
                        state   <= S_BUSY;
                    end else if (!id_eligible) begin
                        irq_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (complete_fire) begin
                        inserv <= inserv & ~id_hit;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cfg_rd_data = '0;
        if (cfg_rd_en) begin
            case (cfg_addr)
                IRQ_REG_ENABLE:  cfg_rd_data[NUM_SRC-1:0]   = enable;
                IRQ_REG_PENDING: cfg_rd_data[NUM_SRC-1:0]   = pending;
                IRQ_REG_EDGE:    cfg_rd_data[NUM_SRC-1:0]   = edge_sel;
                IRQ_REG_PRIO:    cfg_rd_data[PRIO_BITS-1:0] = prio;
                IRQ_REG_THRESH:  cfg_rd_data[PRIO_W-1:0]    = thresh;
                IRQ_REG_INSERV:  cfg_rd_data[NUM_SRC-1:0]   = inserv;
                IRQ_REG_STATE:   cfg_rd_data[1:0]           = state;
                default:         cfg_rd_data                = '0;
            endcase
        end
    end

endmodule

// File: doc/irq_arbiter_ctrl.md
# irq_arbiter_ctrl

Prioritising interrupt controller that sits between the peripheral interrupt lines (UART0, TIMER0/1, GPIOA/B/C) and the core trap unit. It latches per-source pending state, applies enable, per-source priority and a global threshold, and presents one winning interrupt at a time to the trap unit over a request/claim/complete handshake. Software configures it through a small CSR-style register port driven by the CSR module.

## Interface
- NUM_SRC, 10: number of interrupt sources; legal range 1..16.
- PRIO_W, 2: priority field width. Priority 0 means never interrupt.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- src_irq  in  NUM_SRC  raw interrupt lines, synchronous to clk
- cfg_rd_en  in  1  register read strobe
- cfg_wr_en  in  1  register write strobe
- cfg_addr  in  3  register index
- cfg_wr_data  in  32  write data
- cfg_rd_data  out  32  read data, combinational; 0 when cfg_rd_en is low
- irq_req  out  1  interrupt request to the trap unit
- irq_id  out  5  winning source index, valid while irq_req is high
- irq_claim  in  1  trap unit has taken irq_id; honoured only while irq_req is high
- irq_complete  in  1  handler finished (mret path)
- irq_complete_id  in  5  source being completed

## Operation
- Registers, one bit or field per source, bits above NUM_SRC read as 0:
  - 0 ENABLE: RW
  - 1 PENDING: read; write-1-to-clear, edge sources only
  - 2 EDGE: RW; 1 selects rising-edge mode, 0 selects level mode
  - 3 PRIO: RW; PRIO_W bits per source, source i at bits [i*PRIO_W +: PRIO_W]
  - 4 THRESH: RW; bits [PRIO_W-1:0]
  - 5 INSERV: RO
  - 6 STATE: RO; bits [1:0] hold the FSM state
  - 7: reads 0
- Pending:
  - Level mode: pending[i] is registered from src_irq[i] every cycle.
  - Edge mode: pending[i] is set when src_irq[i] is high and the registered previous value is low. It is cleared by claim of i or by W1C.
- Eligible set = pending & ENABLE & ~INSERV & (PRIO > THRESH).
- Winner is the eligible source with the highest PRIO; ties go to the lowest index.
- FSM (S_IDLE=0, S_REQ=1, S_BUSY=2):
  - S_IDLE: if any source is eligible, register the winner into irq_id, set irq_req, and go to S_REQ.
  - S_REQ: irq_id is held stable.
    - If irq_claim: set INSERV[irq_id], clear pending if the source is edge mode, drop irq_req, go to S_BUSY.
    - Else if irq_id is no longer eligible (disabled, W1C, or level dropped): drop irq_req and go to S_IDLE. The request is withdrawn.
  - S_BUSY: no new request, so there is no nesting. If irq_complete and irq_complete_id == held id: clear INSERV bit, go to S_IDLE. A mismatched id is ignored.
- irq_complete in S_IDLE or S_REQ is ignored.

## Timing
- Reset values: every register, the FSM (S_IDLE), irq_req and irq_id are 0; cfg_rd_data is 0. Reset mid-handshake abandons all state immediately.
- Latency: src_irq sampled high at edge k → pending visible after k → irq_req high after edge k+1.
- Claim at edge k → irq_req low after k. Complete at edge k → a new irq_req is possible after edge k+1.
- Config writes take effect at the next edge and are seen by arbitration in the following cycle.
- Simultaneous events:
  - New edge and W1C of the same bit in the same cycle: set wins.
  - New edge and claim of the same source in the same cycle: pending stays set.
  - Claim and withdrawal condition in the same cycle: claim wins.
  - cfg write and hardware update of the same PENDING or INSERV bit: hardware wins.

## Structure
- Shared package (ranger): typedef enum for the FSM states; register index constants IRQ_REG_ENABLE..IRQ_REG_STATE; IRQ_ID_W=5.
- Sub-module irq_prio_sel: combinational eligible-set → {found, id} selector, parameterised by NUM_SRC and PRIO_W.

## Test plan
- Edge source 3, PRIO=2, THRESH=0, enabled; one-cycle pulse on src_irq[3] → irq_req high two edges later with irq_id=3; claim → INSERV=0x8, PENDING[3]=0.
- Sources 1 and 4 pending together with PRIO 1 and 3 → irq_id=4. With equal PRIO 2 → irq_id=1.
- Level source 2 in S_REQ drops before claim → irq_req falls and the FSM returns to S_IDLE with no INSERV bit set.
- In S_BUSY on id 5: irq_complete_id=6 → stays in S_BUSY. irq_complete_id=5 → S_IDLE, and a pending source 0 is requested one edge later.
- THRESH=2 with source PRIO=2 → no request. W1C of PENDING coinciding with a new edge → PENDING stays 1.
- Assert rst_n low during S_REQ → irq_req, irq_id, and all registers read 0 immediately.
